fft_stage_sched: RTL and testbench

Stage/butterfly scheduler for the 16-point radix-2 DIT FFT engine. It sits between the load/output control FSM and the shared sample RAM, twiddle ROM and butterfly unit. On `start` it issues the 4 stages × 8 butterflies with correct in-place radix-2 addresses and twiddle indices, and delays write-back by the butterfly pipeline latency. It inserts a drain gap between stages so no read overtakes a pending write, then pulses `done`.

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/fft_wb_delay.sv | 44 ++++
 rtl/fft_stage_sched.sv | 150 +++++++++++++++
 tb/tb_fft_stage_sched.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, scheduler state type and in-place radix-2 DIT address helper
// for the 16-point FFT engine.
package fft_pkg;

  localparam int N_LOG2 = 4;
  localparam int N_PTS  = 1 << N_LOG2;
  localparam int N_BFLY = N_PTS / 2;
  localparam int ADDR_W = N_LOG2;
  localparam int TW_W   = N_LOG2 - 1;
  localparam int STG_W  = $clog2(N_LOG2);
  localparam int B_W    = $clog2(N_BFLY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [TW_W-1:0]   tw;
  } bfly_addr_t;

  // Butterfly b of stage s pairs addresses span apart inside groups of 2*span.
  function automatic bfly_addr_t bfly_addr(input logic [STG_W-1:0] stage,
                                           input logic [B_W-1:0]   b);
    bfly_addr_t        r;
    logic [ADDR_W-1:0] bx, span, pos, grp;
    bx   = ADDR_W'(b);
    span = ADDR_W'(1) << stage;
    pos  = bx & (span - ADDR_W'(1));
    grp  = bx >> stage;
    r.a  = (grp << (stage + 1)) | pos;
    r.b  = r.a + span;
    r.tw = TW_W'(pos << (N_LOG2 - 1 - int'(stage)));
    return r;
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} from butterfly issue to
// write-back, LAT stages deep, fully cleared by reset.
module fft_wb_delay #(
  parameter int LAT = 2,
  parameter int AW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_in,
  input  logic [AW-1:0] addr_a_in,
  input  logic [AW-1:0] addr_b_in,
  output logic          vld_out,
  output logic [AW-1:0] addr_a_out,
  output logic [AW-1:0] addr_b_out
);

  logic          vld_p    [LAT];
  logic [AW-1:0] addr_a_p [LAT];
  logic [AW-1:0] addr_b_p [LAT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        vld_p[i]    <= 1'b0;
        addr_a_p[i] <= '0;
        addr_b_p[i] <= '0;
      end
    end else begin
      vld_p[0]    <= vld_in;
      addr_a_p[0] <= addr_a_in;
      addr_b_p[0] <= addr_b_in;
      for (int i = 1; i < LAT; i++) begin
        vld_p[i]    <= vld_p[i-1];
        addr_a_p[i] <= addr_a_p[i-1];
        addr_b_p[i] <= addr_b_p[i-1];
      end
    end
  end

  assign vld_out    = vld_p[LAT-1];
  assign addr_a_out = addr_a_p[LAT-1];
  assign addr_b_out = addr_b_p[LAT-1];

endmodule

// File: rtl/fft_stage_sched.sv
// Stage/butterfly scheduler for the radix-2 DIT FFT: issues every butterfly with
// registered addresses, delays write-back, and drains between stages.
module fft_stage_sched
  import fft_pkg::*;
#(
  parameter int N_LOG2   = 4,
  parameter int BFLY_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       hold,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_LOG2)-1:0]  stage,
  output logic                       rd_en,
  output logic [N_LOG2-1:0]          rd_addr_a,
  output logic [N_LOG2-1:0]          rd_addr_b,
  output logic [N_LOG2-2:0]          tw_addr,
  output logic                       wr_en,
  output logic [N_LOG2-1:0]          wr_addr_a,
  output logic [N_LOG2-1:0]          wr_addr_b
);

  localparam int CNT_W = $clog2(BFLY_LAT + 1);

  sched_state_t      state_q, state_n;
  logic [B_W-1:0]    b_q, b_n;
  logic [STG_W-1:0]  stage_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              issue;
  logic [STG_W-1:0]  iss_stage;
  logic [B_W-1:0]    iss_b;
  bfly_addr_t        ba;
  logic [N_LOG2-1:0] addr_a_n, addr_b_n;
  logic [N_LOG2-2:0] tw_n;
  logic              done_n;

  // Outputs are registered, so the decision made in a cycle is what the RAM
  // sees in the next one; issue therefore looks at the current state directly.
  always_comb begin
    state_n   = state_q;
    b_n       = b_q;
    stage_n   = stage;
    cnt_n     = cnt_q;
    issue     = 1'b0;
    iss_stage = stage;
    iss_b     = b_q;
    done_n    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          issue     = 1'b1;
          iss_stage = '0;
          iss_b     = '0;
          stage_n   = '0;
          b_n       = B_W'(1);
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          issue = 1'b1;
          if (b_q == B_W'(N_BFLY - 1)) begin
            b_n     = '0;
            cnt_n   = '0;
            state_n = S_DRAIN;
          end else begin
            b_n = b_q + B_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(BFLY_LAT)) begin
          if (stage == STG_W'(N_LOG2 - 1)) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            issue     = 1'b1;
            iss_stage = stage + STG_W'(1);
            iss_b     = '0;
            stage_n   = stage + STG_W'(1);
            b_n       = B_W'(1);
            state_n   = S_ISSUE;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        stage_n = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    ba       = '0;
    addr_a_n = rd_addr_a;
    addr_b_n = rd_addr_b;
    tw_n     = tw_addr;
    if (issue) begin
      ba       = bfly_addr(iss_stage, iss_b);
      addr_a_n = ba.a;
      addr_b_n = ba.b;
      tw_n     = ba.tw;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      b_q       <= '0;
      cnt_q     <= '0;
      stage     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state_q   <= state_n;
      b_q       <= b_n;
      cnt_q     <= cnt_n;
      stage     <= stage_n;
      busy      <= (state_n != S_IDLE);
      done      <= done_n;
      rd_en     <= issue;
      rd_addr_a <= addr_a_n;
      rd_addr_b <= addr_b_n;
      tw_addr   <= tw_n;
    end
  end

  // Write-back boundary: read strobe and addresses delayed by the butterfly latency.
  fft_wb_delay #(
    .LAT (BFLY_LAT),
    .AW  (N_LOG2)
  ) u_wb_delay (
    .clk        (clk),
    .reset      (reset),
    .vld_in     (rd_en),
    .addr_a_in  (rd_addr_a),
    .addr_b_in  (rd_addr_b),
    .vld_out    (wr_en),
    .addr_a_out (wr_addr_a),
    .addr_b_out (wr_addr_b)
  );

endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched: reset, nominal frame, hold, ignored start,
// and mid-frame reset, checked cycle by cycle against hand-derived schedules.
module tb_fft_stage_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  fft_stage_sched #(
    .N_LOG2   (4),
    .BFLY_LAT (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".rd_en"}, 32'(rd_en), 0);
    check({tag, ".wr_en"}, 32'(wr_en), 0);
    check({tag, ".stage"}, 32'(stage), 0);
    check({tag, ".addrs"}, {13'd0, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}, 0);
  endtask

  // Butterfly k (= 8*stage + b) pair/twiddle, written out per stage.
  function automatic int exp_a(input int k);
    int s = k / 8, b = k % 8;
    case (s)
      0: return 2 * b;
      1: return (b / 2) * 4 + (b % 2);
      2: return (b / 4) * 8 + (b % 4);
      default: return b;
    endcase
  endfunction

  function automatic int exp_b(input int k);
    int span_tab [4] = '{1, 2, 4, 8};
    return exp_a(k) + span_tab[k / 8];
  endfunction

  function automatic int exp_tw(input int k);
    int s = k / 8, b = k % 8;
    case (s)
      0: return 0;
      1: return (b % 2) * 4;
      2: return (b % 4) * 2;
      default: return b;
    endcase
  endfunction

  // Which butterfly should be on the read port in cycle c (-1 if none). Nominal
  // issue is 1+10s+b; a hold of hn cycles starting at cycle 15 pushes every
  // butterfly from nominal cycle 16 onward back by hn.
  function automatic int exp_k(input int c, input int hn);
    for (int k = 0; k < 32; k++) begin
      int nom = 1 + 10 * (k / 8) + (k % 8);
      if (hn > 0 && nom >= 16) nom += hn;
      if (nom == c) return k;
    end
    return -1;
  endfunction

  task automatic run_frame(input string tag, input int hn, input bit extra_start);
    int done_c = 41 + hn;
    int last_c = extra_start ? done_c + 3 : done_c + 1;
    start = 1'b1;
    hold  = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      int kr = exp_k(c, hn);
      int kw = exp_k(c - 2, hn);
      check($sformatf("%s.rd_en@%0d", tag, c), 32'(rd_en), 32'(kr >= 0));
      if (kr >= 0 && rd_en === 1'b1) begin
        check($sformatf("%s.rd_a@%0d", tag, c), 32'(rd_addr_a), exp_a(kr));
        check($sformatf("%s.rd_b@%0d", tag, c), 32'(rd_addr_b), exp_b(kr));
        check($sformatf("%s.tw@%0d", tag, c), 32'(tw_addr), exp_tw(kr));
        check($sformatf("%s.stage@%0d", tag, c), 32'(stage), kr / 8);
      end
      check($sformatf("%s.wr_en@%0d", tag, c), 32'(wr_en), 32'(kw >= 0));
      if (kw >= 0 && wr_en === 1'b1) begin
        check($sformatf("%s.wr_a@%0d", tag, c), 32'(wr_addr_a), exp_a(kw));
        check($sformatf("%s.wr_b@%0d", tag, c), 32'(wr_addr_b), exp_b(kw));
      end
      check($sformatf("%s.done@%0d", tag, c), 32'(done), 32'(c == done_c));
      check($sformatf("%s.busy@%0d", tag, c), 32'(busy), 32'(c <= done_c));
      hold  = (hn > 0 && c >= 15 && c < 15 + hn);
      start = extra_start && (c == 20 || c == done_c);
      step();
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) step();
    check_idle("reset");
    reset = 1'b1;
    repeat (2) begin
      step();
      check_idle("post_reset");
    end

    run_frame("nominal", 0, 1'b0);
    run_frame("hold", 3, 1'b0);
    run_frame("ign_start", 0, 1'b1);

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (16) step();
    reset = 1'b0;
    step();
    check_idle("mid_reset");
    reset = 1'b1;
    repeat (3) begin
      step();
      check_idle("after_mid_reset");
    end
    run_frame("restart", 0, 1'b0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
